range_tracker: RTL and testbench
================================

# range_tracker

Parametrised successor to the chip's single-mode range finder. Tracks the running minimum and maximum of a `data_in` stream between a `go` and a `finish` strobe. On `finish` it reports one of four statistics: range, min, max or midpoint. It also reports the number of samples seen, with a registered one-cycle valid pulse and a sticky protocol-error flag. It sits between the chip's input pins and the 7-segment display driver in `my_chip`.

## Interface
- `WIDTH`, 8: sample and result width in bits.
- `CNT_W`, 8: sample counter width; the counter saturates.
- `clock  in  1  system clock`
- `reset  in  1  reset, asynchronous, active-high`
- `go  in  1  start a measurement; samples data_in in that cycle`
- `finish  in  1  end a measurement; samples data_in in that cycle`
- `mode  in  2  statistic select, latched on accepted go: 0 RANGE, 1 MIN, 2 MAX, 3 MID`
- `data_in  in  WIDTH  unsigned sample`
- `result  out  WIDTH  selected statistic of last completed measurement`
- `sample_count  out  CNT_W  samples in last completed measurement, saturating`
- `result_valid  out  1  one-cycle pulse when result/sample_count update`
- `busy  out  1  high while in TRACK`
- `error  out  1  high while in ERROR`

## Operation
- States: IDLE, TRACK, ERROR. On reset: IDLE, low/high/count/mode registers 0, all outputs 0.
- IDLE:
  - `finish` moves to ERROR; `finish` has priority over a simultaneous `go`.
  - Otherwise `go` moves to TRACK. It loads low=high=data_in, count=1 and latches `mode`.
- TRACK, no `finish`:
  - low=min(low,data_in), high=max(high,data_in).
  - count+1, saturating at 2^CNT_W-1.
  - `go` is ignored.
- TRACK, `finish`:
  - Final lo/hi include that cycle's data_in (combinational min/max); final count = count+1, saturating.
  - result is registered per the latched mode:
    - RANGE: hi-lo
    - MIN: lo
    - MAX: hi
    - MID: (lo+hi)>>1, computed at WIDTH+1 bits so there is no overflow.
  - Also registers sample_count and pulses result_valid. Next state IDLE.
- ERROR:
  - `go` (with or without `finish`) behaves as the IDLE `go` load and moves to TRACK.
  - `finish` alone stays in ERROR.
- result and sample_count hold their values until the next completed measurement. They are not cleared by ERROR or by a new `go`.
- All comparisons are unsigned. hi>=lo by construction, so RANGE never underflows.

## Timing
- Accepted `go` at edge N: TRACK from N. The samples taken are those at edges N..M.
- `finish` at edge M: result, sample_count and result_valid are visible after edge M. Latency is one cycle from `finish` sampling.
- result_valid is high exactly one cycle per completed measurement.
- `busy` = (state==TRACK). `error` = (state==ERROR). Both are registered state decodes.
- Back-to-back operation: `go` in the cycle after the `finish` edge is accepted, so there are no dead cycles.
- Reset asserted mid-TRACK: the measurement is abandoned immediately and all outputs go to 0.

## Structure
- Package `range_pkg`: `state_t` enum {IDLE, TRACK, ERROR}, `mode_t` enum {RANGE, MIN, MAX, MID}.
- Sub-module `range_minmax` (combinational, parameter WIDTH):
  - Inputs: lo, hi, sample.
  - Outputs: new_lo, new_hi.
  - Shared by the TRACK update and the finish-cycle final value.
- `my_chip` instantiates `range_tracker` and feeds `result[6:0]`-relevant bits to the existing `seg7`.

## Test plan
- go with data 5, then 9, 2, then finish with data 7, mode RANGE: result=7, count=4, one valid pulse, busy low afterward.
- Same stream in modes MIN, MAX, MID: result 2, 9, 5 respectively.
- WIDTH=8, MID with samples 255 and 253: result=254, with no overflow.
- finish while IDLE: error=1 and it holds. finish again keeps error=1. go with data 4, then finish with data 4: error clears, RANGE result=0, count=2.
- go+finish in the same cycle from IDLE goes to ERROR; result is unchanged and there is no valid pulse.
- CNT_W=3, 10 samples: sample_count=7. Reset asserted mid-TRACK: all outputs 0 and state IDLE.

Source files
------------

// File: rtl/range_pkg.sv
// range_pkg: shared state and statistic-select types for range_tracker
package range_pkg;
  typedef enum logic [1:0] {IDLE, TRACK, ERROR} state_t;
  typedef enum logic [1:0] {RANGE, MIN, MAX, MID} mode_t;
endpackage

// File: rtl/range_tracker_if.sv
// range_tracker_if: measurement control and result bus for range_tracker
interface range_tracker_if #(parameter int WIDTH = 8, parameter int CNT_W = 8);
  logic go;
  logic finish;
  logic [1:0] mode;
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] result;
  logic [CNT_W-1:0] sample_count;
  logic result_valid;
  logic busy;
  logic error;
  modport master (output go, finish, mode, data_in, input result, sample_count, result_valid, busy, error);
  modport slave (input go, finish, mode, data_in, output result, sample_count, result_valid, busy, error);
endinterface

// File: rtl/range_minmax.sv
// range_minmax: fold one sample into a running unsigned min/max pair
module range_minmax #(parameter int WIDTH = 8) (
  input  logic [WIDTH-1:0] lo,
  input  logic [WIDTH-1:0] hi,
  input  logic [WIDTH-1:0] sample,
  output logic [WIDTH-1:0] new_lo,
  output logic [WIDTH-1:0] new_hi
);
  assign new_lo = sample < lo ? sample : lo;
  assign new_hi = sample > hi ? sample : hi;
endmodule

// File: rtl/range_tracker.sv
// range_tracker: running min/max tracker reporting range, min, max or midpoint on finish
module range_tracker
  import range_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input logic clock,
  input logic reset,
  range_tracker_if.slave bus
);
  state_t state, state_n;
  mode_t mode_q;
  logic [WIDTH-1:0] lo_q, hi_q, new_lo, new_hi, stat;
  logic [CNT_W-1:0] cnt_q, cnt_inc;
  logic [WIDTH:0] sum;
  logic load, done;
  range_minmax #(.WIDTH(WIDTH)) u_minmax (
    .lo(lo_q),
    .hi(hi_q),
    .sample(bus.data_in),
    .new_lo(new_lo),
    .new_hi(new_hi)
  );
  assign cnt_inc = &cnt_q ? cnt_q : cnt_q + 1'b1;
  assign sum = {1'b0, new_lo} + {1'b0, new_hi};
  assign stat = mode_q == RANGE ? new_hi - new_lo :
                mode_q == MIN   ? new_lo :
                mode_q == MAX   ? new_hi : sum[WIDTH:1];
  assign load = bus.go && (state == ERROR || (state == IDLE && !bus.finish));
  assign done = state == TRACK && bus.finish;
  assign bus.busy = state == TRACK;
  assign bus.error = state == ERROR;
  // next state: finish wins over go in IDLE, go wins over finish in ERROR
  always_comb begin
    state_n = state;
    if (load) state_n = TRACK;
    else if (done) state_n = IDLE;
    else if (state == IDLE && bus.finish) state_n = ERROR;
  end
  // state, tracking registers and registered results
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      mode_q <= RANGE;
      lo_q <= '0;
      hi_q <= '0;
      cnt_q <= '0;
      bus.result <= '0;
      bus.sample_count <= '0;
      bus.result_valid <= 1'b0;
    end else begin
      state <= state_n;
      bus.result_valid <= done;
      if (load) begin
        mode_q <= mode_t'(bus.mode);
        lo_q <= bus.data_in;
        hi_q <= bus.data_in;
        cnt_q <= CNT_W'(1);
      end else if (state == TRACK && !bus.finish) begin
        lo_q <= new_lo;
        hi_q <= new_hi;
        cnt_q <= cnt_inc;
      end
      if (done) begin
        bus.result <= stat;
        bus.sample_count <= cnt_inc;
      end
    end
  end
endmodule

// File: tb/tb_range_tracker.sv
// tb_range_tracker: scoreboard bench comparing two range_tracker instances against a sample-list model
module tb_range_tracker;
  typedef struct {int res; int cnt8; int cnt3;} exp_t;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;
  exp_t qa[$];
  exp_t qb[$];
  int mst = 0;
  int md = 0;
  int smp[$];
  range_tracker_if #(.WIDTH(8), .CNT_W(8)) ifa ();
  range_tracker_if #(.WIDTH(8), .CNT_W(3)) ifb ();
  assign ifb.go = ifa.go;
  assign ifb.finish = ifa.finish;
  assign ifb.mode = ifa.mode;
  assign ifb.data_in = ifa.data_in;
  range_tracker #(.WIDTH(8), .CNT_W(8)) dut_a (.clock(clock), .reset(reset), .bus(ifa));
  range_tracker #(.WIDTH(8), .CNT_W(3)) dut_b (.clock(clock), .reset(reset), .bus(ifb));
  always #5 clock = ~clock;
  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
    end
  endtask
  function automatic exp_t expect_of();
    exp_t e;
    int lo = smp[0];
    int hi = smp[0];
    foreach (smp[i]) begin
      if (smp[i] < lo) lo = smp[i];
      if (smp[i] > hi) hi = smp[i];
    end
    e.res = md == 0 ? hi - lo : md == 1 ? lo : md == 2 ? hi : (lo + hi) / 2;
    e.cnt8 = smp.size() > 255 ? 255 : smp.size();
    e.cnt3 = smp.size() > 7 ? 7 : smp.size();
    return e;
  endfunction
  task automatic step(input bit g, input bit f, input int m, input int d);
    exp_t e;
    @(negedge clock);
    ifa.go = g;
    ifa.finish = f;
    ifa.mode = 2'(m);
    ifa.data_in = 8'(d);
    if (mst == 1) begin
      smp.push_back(d);
      if (f) begin
        e = expect_of();
        qa.push_back(e);
        qb.push_back(e);
        mst = 0;
      end
    end else if (g && !(mst == 0 && f)) begin
      smp = {d};
      md = m;
      mst = 1;
    end else if (f) mst = 2;
    @(posedge clock);
    #1;
    chk("busy_a", int'(ifa.busy), int'(mst == 1));
    chk("error_a", int'(ifa.error), int'(mst == 2));
    chk("busy_b", int'(ifb.busy), int'(mst == 1));
    chk("error_b", int'(ifb.error), int'(mst == 2));
  endtask
  task automatic chk_zero();
    chk("rst_result_a", int'(ifa.result), 0);
    chk("rst_count_a", int'(ifa.sample_count), 0);
    chk("rst_valid_a", int'(ifa.result_valid), 0);
    chk("rst_busy_a", int'(ifa.busy), 0);
    chk("rst_error_a", int'(ifa.error), 0);
    chk("rst_result_b", int'(ifb.result), 0);
    chk("rst_count_b", int'(ifb.sample_count), 0);
  endtask
  task automatic run(input int m, input int n);
    step(1, 0, m, $urandom_range(255));
    for (int i = 0; i < n; i++) step(0, 0, m, $urandom_range(255));
    step(0, 1, m, $urandom_range(255));
  endtask
  always @(negedge clock) begin
    exp_t e;
    if (!reset && ifa.result_valid) begin
      if (qa.size() == 0) chk("a_spurious_valid", 1, 0);
      else begin
        e = qa.pop_front();
        chk("a_result", int'(ifa.result), e.res);
        chk("a_count", int'(ifa.sample_count), e.cnt8);
      end
    end
  end
  always @(negedge clock) begin
    exp_t e;
    if (!reset && ifb.result_valid) begin
      if (qb.size() == 0) chk("b_spurious_valid", 1, 0);
      else begin
        e = qb.pop_front();
        chk("b_result", int'(ifb.result), e.res);
        chk("b_count", int'(ifb.sample_count), e.cnt3);
      end
    end
  end
  initial begin
    int held;
    ifa.go = 1'b0;
    ifa.finish = 1'b0;
    ifa.mode = 2'd0;
    ifa.data_in = 8'd0;
    repeat (3) @(posedge clock);
    #1;
    chk_zero();
    @(negedge clock);
    reset = 1'b0;
    for (int m = 0; m < 4; m++) begin
      step(1, 0, m, 5);
      step(0, 0, m, 9);
      step(0, 0, m, 2);
      step(0, 1, m, 7);
    end
    step(1, 0, 3, 255);
    step(0, 1, 3, 253);
    held = int'(ifa.result);
    step(0, 1, 0, 1);
    step(0, 1, 0, 1);
    chk("err_hold_result", int'(ifa.result), held);
    step(1, 0, 0, 4);
    step(0, 1, 0, 4);
    held = int'(ifa.result);
    step(1, 1, 2, 3);
    chk("gofin_hold_result", int'(ifa.result), held);
    step(1, 1, 2, 3);
    step(1, 0, 2, 99);
    step(0, 1, 2, 8);
    step(1, 0, 0, 10);
    for (int i = 0; i < 8; i++) step(0, 0, 0, 20 + i);
    step(0, 1, 0, 1);
    run(1, 300);
    for (int i = 0; i < 400; i++)
      step($urandom_range(9) < 3, $urandom_range(9) < 2, $urandom_range(3), $urandom_range(255));
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    for (int m = 0; m < 4; m++) run(m, $urandom_range(12));
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    step(1, 0, 1, 50);
    step(0, 0, 1, 60);
    #2;
    reset = 1'b1;
    #1;
    chk_zero();
    mst = 0;
    smp.delete();
    @(negedge clock);
    reset = 1'b0;
    step(0, 0, 0, 0);
    run(0, 3);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    chk("a_pending", qa.size(), 0);
    chk("b_pending", qb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
